// File: rtl/forwarding_stall_ctrl_pkg.sv
// Shared types and hazard bit map for the forwarding / stall controller.
package forwarding_stall_ctrl_pkg;

    localparam int unsigned HAZ_W_DEF = 11;

    // Bit positions in the decode hazard vector
    localparam int unsigned HAZ_R1_S3     = 0;
    localparam int unsigned HAZ_R1_S2     = 1;
    localparam int unsigned HAZ_R2_S2     = 2;
    localparam int unsigned HAZ_R2_S3     = 3;
    localparam int unsigned HAZ_CMP_S2    = 4;
    localparam int unsigned HAZ_CMP_S3    = 5;
    localparam int unsigned HAZ_R0_S2     = 6;
    localparam int unsigned HAZ_R0_S3     = 7;
    localparam int unsigned HAZ_SW_S2_LW  = 8;
    localparam int unsigned HAZ_SW_S3_LW  = 9;
    localparam int unsigned HAZ_SW_S2_ALU = 10;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_S2   = 2'b01,
        FWD_S3   = 2'b10,
        FWD_MEM  = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LD_STALL = 2'b01,
        BR_FLUSH = 2'b10
    } ctrl_state_t;

    typedef struct packed {
        fwd_sel_t a;
        fwd_sel_t b;
        fwd_sel_t cmp;
        fwd_sel_t r0;
        fwd_sel_t sw;
    } fwd_sels_t;

    localparam fwd_sels_t SELS_NONE = '{a: FWD_NONE, b: FWD_NONE, cmp: FWD_NONE,
                                        r0: FWD_NONE, sw: FWD_NONE};

    // Nearer pipeline stage wins whenever both stage bits of a source are set
    function automatic fwd_sels_t fwd_decode(input logic [HAZ_W_DEF-1:0] h);
        fwd_sels_t s;
        s = SELS_NONE;
        if (h[HAZ_R1_S2])         s.a = FWD_S2;
        else if (h[HAZ_R1_S3])    s.a = FWD_S3;
        if (h[HAZ_R2_S2])         s.b = FWD_S2;
        else if (h[HAZ_R2_S3])    s.b = FWD_S3;
        if (h[HAZ_CMP_S2])        s.cmp = FWD_S2;
        else if (h[HAZ_CMP_S3])   s.cmp = FWD_S3;
        if (h[HAZ_R0_S2])         s.r0 = FWD_S2;
        else if (h[HAZ_R0_S3])    s.r0 = FWD_S3;
        if (h[HAZ_SW_S2_LW])      s.sw = FWD_MEM;
        else if (h[HAZ_SW_S2_ALU]) s.sw = FWD_S2;
        else if (h[HAZ_SW_S3_LW]) s.sw = FWD_S3;
        return s;
    endfunction

endpackage

// File: rtl/forwarding_stall_ctrl_hazard_stall_fsm.sv
// Load-use stall / branch flush sequencer driving the pipeline enables.
module forwarding_stall_ctrl_hazard_stall_fsm
    import forwarding_stall_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic branch_taken,
    output logic pc_we,
    output logic ifid_we,
    output logic ifid_flush,
    output logic idex_bubble,
    output logic busy
);

    localparam int unsigned MAX_CYC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
    localparam int unsigned CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CYC_W-1:0] STALL_LOAD = CYC_W'(STALL_CYCLES - 1);
    localparam logic [CYC_W-1:0] FLUSH_LOAD = CYC_W'(FLUSH_CYCLES - 1);

    ctrl_state_t      state_q, state_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Branch flush always preempts a pending or requested load-use stall
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        busy        = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    state_d = BR_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (stall) begin
                    state_d = LD_STALL;
                    cnt_d   = STALL_LOAD;
                end
            end
            LD_STALL: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                busy        = 1'b1;
                if (branch_taken) begin
                    state_d = BR_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CYC_W'(1);
                end
            end
            BR_FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                busy        = 1'b1;
                if (branch_taken) begin
                    cnt_d = FLUSH_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CYC_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/forwarding_stall_ctrl.sv
// Forwarding select registers, stall/flush sequencing and stall-cycle counter
// between decode hazard detection and the EX-stage muxes.
module forwarding_stall_ctrl
    import forwarding_stall_ctrl_pkg::*;
#(
    parameter int unsigned HAZ_W        = HAZ_W_DEF,
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [HAZ_W-1:0] haz,
    input  logic             stall,
    input  logic             branch_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output fwd_sel_t         fwd_a_sel,
    output fwd_sel_t         fwd_b_sel,
    output fwd_sel_t         fwd_cmp_sel,
    output fwd_sel_t         fwd_r0_sel,
    output fwd_sel_t         fwd_sw_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    fwd_sels_t sels_d, sels_q;
    logic      busy;

    forwarding_stall_ctrl_hazard_stall_fsm #(
        .STALL_CYCLES (STALL_CYCLES),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_hazard_stall_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .busy         (busy)
    );

    // A NOP entering EX must never pick up a forwarded operand
    always_comb begin
        sels_d = fwd_decode(haz[HAZ_W_DEF-1:0]);
        if (idex_bubble) begin
            sels_d = SELS_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sels_q <= SELS_NONE;
        end else begin
            sels_q <= sels_d;
        end
    end

    // Saturating count of cycles spent outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (busy && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign fwd_a_sel   = sels_q.a;
    assign fwd_b_sel   = sels_q.b;
    assign fwd_cmp_sel = sels_q.cmp;
    assign fwd_r0_sel  = sels_q.r0;
    assign fwd_sw_sel  = sels_q.sw;

endmodule

// File: tb/tb_forwarding_stall_ctrl.sv
// Directed bench for forwarding_stall_ctrl (STALL_CYCLES=2, FLUSH_CYCLES=1, CNT_W=4).
module tb_forwarding_stall_ctrl;
    import forwarding_stall_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] haz;
    logic        stall;
    logic        branch_taken;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble;
    fwd_sel_t    fwd_a_sel, fwd_b_sel, fwd_cmp_sel, fwd_r0_sel, fwd_sw_sel;
    logic [3:0]  stall_cnt;

    int checks = 0;
    int passed = 0;

    forwarding_stall_ctrl #(
        .HAZ_W        (11),
        .STALL_CYCLES (2),
        .FLUSH_CYCLES (1),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .haz          (haz),
        .stall        (stall),
        .branch_taken (branch_taken),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .fwd_cmp_sel  (fwd_cmp_sel),
        .fwd_r0_sel   (fwd_r0_sel),
        .fwd_sw_sel   (fwd_sw_sel),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        haz = '0; stall = 1'b0; branch_taken = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b1100) $display("FAIL reset_en: got %b expected 1100", {pc_we, ifid_we, ifid_flush, idex_bubble}); else passed++;
        checks++; if ({fwd_a_sel, fwd_b_sel, fwd_cmp_sel, fwd_r0_sel, fwd_sw_sel} !== 10'h0) $display("FAIL reset_sel: got %h expected 000", {fwd_a_sel, fwd_b_sel, fwd_cmp_sel, fwd_r0_sel, fwd_sw_sel}); else passed++;
        checks++; if (stall_cnt !== 4'h0) $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); else passed++;
    endtask

    task automatic test_priority();
        haz = 11'h003; tick();
        checks++; if (fwd_a_sel !== FWD_S2) $display("FAIL prio_a_003: got %0d expected %0d", fwd_a_sel, FWD_S2); else passed++;
        haz = 11'h009; tick();
        checks++; if (fwd_a_sel !== FWD_S3) $display("FAIL prio_a_009: got %0d expected %0d", fwd_a_sel, FWD_S3); else passed++;
        checks++; if (fwd_b_sel !== FWD_S3) $display("FAIL prio_b_009: got %0d expected %0d", fwd_b_sel, FWD_S3); else passed++;
        haz = 11'h700; tick();
        checks++; if (fwd_sw_sel !== FWD_MEM) $display("FAIL prio_sw_700: got %0d expected %0d", fwd_sw_sel, FWD_MEM); else passed++;
        haz = 11'h600; tick();
        checks++; if (fwd_sw_sel !== FWD_S2) $display("FAIL prio_sw_600: got %0d expected %0d", fwd_sw_sel, FWD_S2); else passed++;
        haz = 11'h200; tick();
        checks++; if (fwd_sw_sel !== FWD_S3) $display("FAIL prio_sw_200: got %0d expected %0d", fwd_sw_sel, FWD_S3); else passed++;
        haz = 11'h0F0; tick();
        checks++; if ({fwd_cmp_sel, fwd_r0_sel} !== {FWD_S2, FWD_S2}) $display("FAIL prio_cmp_r0_0F0: got %b expected 0101", {fwd_cmp_sel, fwd_r0_sel}); else passed++;
        haz = 11'h0A0; tick();
        checks++; if ({fwd_cmp_sel, fwd_r0_sel} !== {FWD_S3, FWD_S3}) $display("FAIL prio_cmp_r0_0A0: got %b expected 1010", {fwd_cmp_sel, fwd_r0_sel}); else passed++;
        haz = 11'h00C; tick();
        checks++; if ({fwd_a_sel, fwd_b_sel} !== {FWD_NONE, FWD_S2}) $display("FAIL prio_b_00C: got %b expected 0001", {fwd_a_sel, fwd_b_sel}); else passed++;
        haz = 11'h000; tick();
        checks++; if ({fwd_a_sel, fwd_b_sel, fwd_cmp_sel, fwd_r0_sel, fwd_sw_sel} !== 10'h0) $display("FAIL prio_none: got %h expected 000", {fwd_a_sel, fwd_b_sel, fwd_cmp_sel, fwd_r0_sel, fwd_sw_sel}); else passed++;
    endtask

    task automatic test_load_use();
        stall = 1'b1; tick();
        stall = 1'b0;
        checks++; if ({pc_we, ifid_we, idex_bubble} !== 3'b001) $display("FAIL ld_cyc1: got %b expected 001", {pc_we, ifid_we, idex_bubble}); else passed++;
        tick();
        checks++; if ({pc_we, ifid_we, idex_bubble} !== 3'b001) $display("FAIL ld_cyc2: got %b expected 001", {pc_we, ifid_we, idex_bubble}); else passed++;
        tick();
        checks++; if ({pc_we, ifid_we, idex_bubble} !== 3'b110) $display("FAIL ld_run: got %b expected 110", {pc_we, ifid_we, idex_bubble}); else passed++;
        checks++; if (stall_cnt !== 4'd2) $display("FAIL ld_cnt: got %0d expected 2", stall_cnt); else passed++;
    endtask

    task automatic test_flush_priority();
        stall = 1'b1; branch_taken = 1'b1; tick();
        stall = 1'b0; branch_taken = 1'b0;
        checks++; if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b1111) $display("FAIL flush_prio: got %b expected 1111", {pc_we, ifid_we, ifid_flush, idex_bubble}); else passed++;
        tick();
        checks++; if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b1100) $display("FAIL flush_end: got %b expected 1100", {pc_we, ifid_we, ifid_flush, idex_bubble}); else passed++;
        tick();
        checks++; if ({pc_we, idex_bubble} !== 2'b10) $display("FAIL flush_no_stall: got %b expected 10", {pc_we, idex_bubble}); else passed++;
        checks++; if (stall_cnt !== 4'd3) $display("FAIL flush_cnt: got %0d expected 3", stall_cnt); else passed++;
    endtask

    task automatic test_branch_cases();
        // back-to-back branches restart the flush window
        branch_taken = 1'b1; tick();
        tick();
        branch_taken = 1'b0;
        checks++; if (ifid_flush !== 1'b1) $display("FAIL flush_restart: got %b expected 1", ifid_flush); else passed++;
        tick();
        checks++; if (ifid_flush !== 1'b0) $display("FAIL flush_restart_end: got %b expected 0", ifid_flush); else passed++;
        // branch during a load-use stall preempts it
        stall = 1'b1; tick();
        stall = 1'b0; branch_taken = 1'b1;
        checks++; if (pc_we !== 1'b0) $display("FAIL preempt_ld: got %b expected 0", pc_we); else passed++;
        tick();
        branch_taken = 1'b0;
        checks++; if ({pc_we, ifid_flush, idex_bubble} !== 3'b111) $display("FAIL preempt_flush: got %b expected 111", {pc_we, ifid_flush, idex_bubble}); else passed++;
        tick();
        checks++; if ({pc_we, ifid_flush, idex_bubble} !== 3'b100) $display("FAIL preempt_run: got %b expected 100", {pc_we, ifid_flush, idex_bubble}); else passed++;
        checks++; if (stall_cnt !== 4'd7) $display("FAIL branch_cnt: got %0d expected 7", stall_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        stall = 1'b1; tick();
        tick();
        tick();
        checks++; if (pc_we !== 1'b1) $display("FAIL b2b_run_gap: got %b expected 1", pc_we); else passed++;
        tick();
        checks++; if ({pc_we, idex_bubble} !== 2'b01) $display("FAIL b2b_reenter: got %b expected 01", {pc_we, idex_bubble}); else passed++;
        stall = 1'b0;
        tick();
        tick();
        checks++; if ({pc_we, idex_bubble} !== 2'b10) $display("FAIL b2b_exit: got %b expected 10", {pc_we, idex_bubble}); else passed++;
    endtask

    task automatic test_bubble_mask();
        do_reset();
        haz = 11'h000; stall = 1'b1; tick();
        stall = 1'b0; haz = 11'h002;
        checks++; if (fwd_a_sel !== FWD_NONE) $display("FAIL mask_ld1: got %0d expected %0d", fwd_a_sel, FWD_NONE); else passed++;
        tick();
        checks++; if (fwd_a_sel !== FWD_NONE) $display("FAIL mask_ld2: got %0d expected %0d", fwd_a_sel, FWD_NONE); else passed++;
        tick();
        checks++; if ({pc_we, fwd_a_sel} !== {1'b1, FWD_NONE}) $display("FAIL mask_run: got %b expected 100", {pc_we, fwd_a_sel}); else passed++;
        tick();
        checks++; if (fwd_a_sel !== FWD_S2) $display("FAIL mask_release: got %0d expected %0d", fwd_a_sel, FWD_S2); else passed++;
        haz = 11'h000;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        haz = 11'h002; stall = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if ({idex_bubble, fwd_a_sel, stall_cnt} !== {1'b1, FWD_S2, 4'd2}) $display("FAIL pre_reset: got %b expected 1010010", {idex_bubble, fwd_a_sel, stall_cnt}); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b1100) $display("FAIL async_rst_en: got %b expected 1100", {pc_we, ifid_we, ifid_flush, idex_bubble}); else passed++;
        checks++; if ({fwd_a_sel, stall_cnt} !== {FWD_NONE, 4'd0}) $display("FAIL async_rst_sel_cnt: got %b expected 000000", {fwd_a_sel, stall_cnt}); else passed++;
        haz = '0; stall = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        int busy_cycles;
        int exp_cnt;
        do_reset();
        busy_cycles = 0;
        stall = 1'b1;
        // held stall cycles LD,LD,RUN: cycle k is busy when k%3 != 0
        for (int k = 0; k < 35; k++) begin
            tick();
            if ((k % 3) != 0) busy_cycles++;
            exp_cnt = (busy_cycles > 15) ? 15 : busy_cycles;
            checks++; if (stall_cnt !== 4'(exp_cnt)) $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, stall_cnt, exp_cnt); else passed++;
        end
        checks++; if (stall_cnt !== 4'hF) $display("FAIL sat_hold: got %0h expected F", stall_cnt); else passed++;
        stall = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        haz = '0; stall = 1'b0; branch_taken = 1'b0;
        test_reset();
        test_priority();
        test_load_use();
        test_flush_priority();
        test_branch_cases();
        test_back_to_back();
        test_bubble_mask();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
